// File: rtl/alu_writeback_pkg.sv
// ---------------------------------------------------------------------------
// alu_writeback_pkg
//   Shared definitions for the ALU write-back slice:
//     - alu_func_e : ALU function codes (ADD=0 .. PASS=7)
//     - FLAG_*     : bit positions of the flags register {V,C,N,Z}
//     - func_sets_carry() : which functions report a carry in the C flag
// ---------------------------------------------------------------------------
package alu_writeback_pkg;

  typedef enum logic [2:0] {
    FUNC_ADD  = 3'd0,
    FUNC_SUB  = 3'd1,
    FUNC_AND  = 3'd2,
    FUNC_OR   = 3'd3,
    FUNC_XOR  = 3'd4,
    FUNC_SHL  = 3'd5,
    FUNC_SHR  = 3'd6,
    FUNC_PASS = 3'd7
  } alu_func_e;

  localparam int FLAG_Z    = 0;
  localparam int FLAG_N    = 1;
  localparam int FLAG_C    = 2;
  localparam int FLAG_V    = 3;
  localparam int FLAG_BITS = 4;

  // Arithmetic and shift operations produce a meaningful carry/shift-out;
  // logic ops and PASS never set C.
  function automatic logic func_sets_carry(input alu_func_e func);
    return func inside {FUNC_ADD, FUNC_SUB, FUNC_SHL, FUNC_SHR};
  endfunction

endpackage

// File: rtl/alu_wb_skid.sv
// ---------------------------------------------------------------------------
// alu_wb_skid
//   Two-entry valid/ready buffer between the ALU and the register-file write
//   port. The head entry is always held in head_q so o_data comes straight
//   from a register; tail_q holds the second entry while the consumer stalls.
//   o_ready is registered and asserts whenever the buffer will hold fewer
//   than two entries after the current edge.
//
// Ports
//   i_clk    in   clock, rising edge
//   i_rst    in   synchronous reset, active-high (empties the buffer)
//   i_valid  in   producer has an entry
//   o_ready  out  buffer can accept (registered)
//   i_data   in   DATA_BITS payload from producer
//   o_valid  out  head entry available
//   i_ready  in   consumer takes the head entry
//   o_data   out  DATA_BITS head payload
// ---------------------------------------------------------------------------
module alu_wb_skid #(
  parameter int DATA_BITS = 11
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [DATA_BITS-1:0] i_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [DATA_BITS-1:0] o_data
);

  logic [1:0]           count_q;
  logic [1:0]           count_d;
  logic                 ready_q;
  logic [DATA_BITS-1:0] head_q;
  logic [DATA_BITS-1:0] tail_q;
  logic                 accept;
  logic                 drain;

  assign accept  = i_valid & ready_q;
  assign drain   = (count_q != 2'd0) & i_ready;
  assign o_ready = ready_q;
  assign o_valid = (count_q != 2'd0);
  assign o_data  = head_q;

  // NOTE: count_d gets a default before the case so every path assigns it;
  // a missing default in always_comb would infer a latch.
  always_comb begin
    count_d = count_q;
    case ({accept, drain})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      count_q <= 2'd0;
      ready_q <= 1'b1;
      // NOTE: the two storage slots are reset because the head drives o_data
      // directly and must read zero after reset; in larger buffers storage
      // would normally be left unreset.
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      count_q <= count_d;
      ready_q <= (count_d < 2'd2);

      // Head loads a new entry when the buffer is empty, or when the only
      // entry leaves on the same edge; otherwise it promotes the tail.
      if (accept && ((count_q == 2'd0) || ((count_q == 2'd1) && drain))) begin
        head_q <= i_data;
      end else if (drain && (count_q == 2'd2)) begin
        head_q <= tail_q;
      end

      // Tail only fills when a second entry arrives behind a stalled head.
      if (accept && (count_q == 2'd1) && !drain) begin
        tail_q <= i_data;
      end
    end
  end

endmodule

// File: rtl/alu_writeback.sv
// ---------------------------------------------------------------------------
// alu_writeback
//   Write-back stage of the 8-bit SISD ALU. On each accepted ALU result it
//   derives the Z/N/C/V flags, optionally updates the architectural flags
//   register, and pushes {rd, result} into a 2-entry skid buffer toward the
//   register-file write port. Counts entries drained to the register file.
//
// Configuration
//   ALU_WB_SAT_EN : when defined, an ADD with carry-out saturates the result
//                   to all ones; flags are then taken from the saturated
//                   value (C still reports the carry). Undefined by default.
//
// Ports
//   i_clk       in   clock, rising edge
//   i_rst       in   synchronous reset, active-high
//   i_valid     in   ALU output valid
//   o_ready     out  stage can accept (registered, buffer not full)
//   i_result    in   ALU result (WIDTH)
//   i_carry     in   ALU unsigned carry-out
//   i_s1_msb    in   MSB of operand s1
//   i_s2_msb    in   MSB of operand s2
//   i_func      in   ALU function code (alu_func_e)
//   i_rd        in   destination register (RD_BITS)
//   i_flags_we  in   update flags register on accept
//   o_valid     out  write-back entry available
//   i_ready     in   register file accepts entry
//   o_rd        out  head entry destination
//   o_data      out  head entry data
//   o_flags     out  flags register {V,C,N,Z}
//   o_retired   out  entries drained to the register file (wraps)
// ---------------------------------------------------------------------------
module alu_writeback
  import alu_writeback_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int RD_BITS  = 3,
  parameter int CNT_BITS = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [WIDTH-1:0]     i_result,
  input  logic                 i_carry,
  input  logic                 i_s1_msb,
  input  logic                 i_s2_msb,
  input  logic [2:0]           i_func,
  input  logic [RD_BITS-1:0]   i_rd,
  input  logic                 i_flags_we,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [RD_BITS-1:0]   o_rd,
  output logic [WIDTH-1:0]     o_data,
  output logic [FLAG_BITS-1:0] o_flags,
  output logic [CNT_BITS-1:0]  o_retired
);

  localparam int DATA_BITS = WIDTH + RD_BITS;

  alu_func_e              func;
  logic [WIDTH-1:0]       result_r;
  logic [FLAG_BITS-1:0]   flags_d;
  logic [FLAG_BITS-1:0]   flags_q;
  logic [CNT_BITS-1:0]    retired_q;
  logic [DATA_BITS-1:0]   head_data;
  logic                   accept;
  logic                   drain;

  assign func   = alu_func_e'(i_func);
  assign accept = i_valid & o_ready;
  assign drain  = o_valid & i_ready;

  // Value actually written back (R); flags are derived from R, not from the
  // raw ALU result, so saturation is reflected in Z/N/V.
  always_comb begin
    result_r = i_result;
`ifdef ALU_WB_SAT_EN
    if ((func == FUNC_ADD) && i_carry) begin
      result_r = '1;
    end
`endif
  end

  // V uses operand sign bits: ADD overflows when both operands share a sign
  // the result lacks; SUB when the operands differ and the result takes the
  // subtrahend's sign.
  always_comb begin
    flags_d         = '0;
    flags_d[FLAG_Z] = (result_r == '0);
    flags_d[FLAG_N] = result_r[WIDTH-1];
    flags_d[FLAG_C] = func_sets_carry(func) & i_carry;
    case (func)
      FUNC_ADD: flags_d[FLAG_V] = (i_s1_msb == i_s2_msb) &
                                  (result_r[WIDTH-1] != i_s1_msb);
      FUNC_SUB: flags_d[FLAG_V] = (i_s1_msb != i_s2_msb) &
                                  (result_r[WIDTH-1] != i_s1_msb);
      default:  flags_d[FLAG_V] = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      flags_q   <= '0;
      retired_q <= '0;
    end else begin
      if (accept && i_flags_we) begin
        flags_q <= flags_d;
      end
      if (drain) begin
        retired_q <= retired_q + CNT_BITS'(1);
      end
    end
  end

  alu_wb_skid #(
    .DATA_BITS (DATA_BITS)
  ) u_skid (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_data  ({i_rd, result_r}),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_data  (head_data)
  );

  assign o_rd      = head_data[DATA_BITS-1:WIDTH];
  assign o_data    = head_data[WIDTH-1:0];
  assign o_flags   = flags_q;
  assign o_retired = retired_q;

endmodule

// File: tb/tb_alu_writeback.sv
// ---------------------------------------------------------------------------
// tb_alu_writeback
//   Self-checking bench for alu_writeback. A queue-based reference model
//   tracks the buffer contents, flags register and retire count; directed
//   vectors, hand-written stall/reset/wrap sequences and random traffic are
//   compared against it and against hand-derived constants.
// ---------------------------------------------------------------------------
module tb_alu_writeback;
  import alu_writeback_pkg::*;

  localparam int WIDTH    = 8;
  localparam int RD_BITS  = 3;
  localparam int CNT_BITS = 16;

  logic                i_clk = 1'b0;
  logic                i_rst;
  logic                i_valid;
  logic                o_ready;
  logic [WIDTH-1:0]    i_result;
  logic                i_carry;
  logic                i_s1_msb;
  logic                i_s2_msb;
  logic [2:0]          i_func;
  logic [RD_BITS-1:0]  i_rd;
  logic                i_flags_we;
  logic                o_valid;
  logic                i_ready;
  logic [RD_BITS-1:0]  o_rd;
  logic [WIDTH-1:0]    o_data;
  logic [3:0]          o_flags;
  logic [CNT_BITS-1:0] o_retired;

  always #5 i_clk = ~i_clk;

  alu_writeback #(
    .WIDTH    (WIDTH),
    .RD_BITS  (RD_BITS),
    .CNT_BITS (CNT_BITS)
  ) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_result   (i_result),
    .i_carry    (i_carry),
    .i_s1_msb   (i_s1_msb),
    .i_s2_msb   (i_s2_msb),
    .i_func     (i_func),
    .i_rd       (i_rd),
    .i_flags_we (i_flags_we),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_rd       (o_rd),
    .o_data     (o_data),
    .o_flags    (o_flags),
    .o_retired  (o_retired)
  );

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [RD_BITS-1:0] rd;
    logic [WIDTH-1:0]   data;
  } entry_t;

  entry_t              mq[$];
  logic [3:0]          m_flags;
  logic [CNT_BITS-1:0] m_retired;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] ref_result(input logic [2:0] f, input logic [WIDTH-1:0] r,
                                                  input logic c);
    logic [WIDTH-1:0] v;
    v = r;
`ifdef ALU_WB_SAT_EN
    if (f == 3'd0 && c) v = {WIDTH{1'b1}};
`endif
    return v;
  endfunction

  // Flags {V,C,N,Z} from the stated rules, using the written-back value.
  function automatic logic [3:0] ref_flags(input logic [2:0] f, input logic [WIDTH-1:0] r,
                                           input logic c, input logic s1, input logic s2);
    logic z, n, cf, v;
    z  = (r == 0);
    n  = r[WIDTH-1];
    cf = (f == 3'd0 || f == 3'd1 || f == 3'd5 || f == 3'd6) ? c : 1'b0;
    if (f == 3'd0)      v = (s1 == s2) && (n != s1);
    else if (f == 3'd1) v = (s1 != s2) && (n != s1);
    else                v = 1'b0;
    return {v, cf, n, z};
  endfunction

  // Drive one cycle of inputs, advance the model across the edge, settle.
  task automatic cycle(input logic rst, input logic v, input logic [2:0] f,
                       input logic [WIDTH-1:0] r, input logic c, input logic s1,
                       input logic s2, input logic [RD_BITS-1:0] rd, input logic we,
                       input logic rdy);
    logic acc, drn;
    logic [WIDTH-1:0] rr;
    entry_t dummy;
    i_rst = rst; i_valid = v; i_func = f; i_result = r; i_carry = c;
    i_s1_msb = s1; i_s2_msb = s2; i_rd = rd; i_flags_we = we; i_ready = rdy;
    acc = !rst && v && (mq.size() < 2);
    drn = !rst && rdy && (mq.size() > 0);
    rr  = ref_result(f, r, c);
    @(posedge i_clk);
    if (rst) begin
      mq.delete();
      m_flags   = '0;
      m_retired = '0;
    end else begin
      if (drn) begin
        dummy = mq.pop_front();
        m_retired = m_retired + 1'b1;
      end
      if (acc) begin
        mq.push_back({rd, rr});
        if (we) m_flags = ref_flags(f, rr, c, s1, s2);
      end
    end
    #1;
  endtask

  task automatic idle(input logic rdy);
    cycle(1'b0, 1'b0, 3'd0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0, rdy);
  endtask

  task automatic check_model(input string tag);
    check({tag, " o_valid"}, o_valid, mq.size() > 0);
    check({tag, " o_ready"}, o_ready, mq.size() < 2);
    if (mq.size() > 0) begin
      check({tag, " o_data"}, o_data, mq[0].data);
      check({tag, " o_rd"}, o_rd, mq[0].rd);
    end
    check({tag, " o_flags"}, o_flags, m_flags);
    check({tag, " o_retired"}, o_retired, m_retired);
  endtask

  task automatic rand_op(output logic [2:0] f, output logic [WIDTH-1:0] r, output logic c,
                         output logic s1, output logic s2);
    logic [WIDTH-1:0] a, b;
    logic [WIDTH:0]   w;
    a = WIDTH'($urandom);
    b = WIDTH'($urandom);
    f = 3'($urandom_range(0, 7));
    c = 1'b0;
    case (f)
      3'd0: begin w = {1'b0, a} + {1'b0, b}; r = w[WIDTH-1:0]; c = w[WIDTH]; end
      3'd1: begin w = {1'b0, a} - {1'b0, b}; r = w[WIDTH-1:0]; c = w[WIDTH]; end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: begin r = {a[WIDTH-2:0], 1'b0}; c = a[WIDTH-1]; end
      3'd6: begin r = {1'b0, a[WIDTH-1:1]}; c = a[0]; end
      default: r = a;
    endcase
    s1 = a[WIDTH-1];
    s2 = b[WIDTH-1];
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [2:0]         func;
    logic [WIDTH-1:0]   result;
    logic               carry;
    logic               s1;
    logic               s2;
    logic [RD_BITS-1:0] rd;
    logic               we;
    logic [WIDTH-1:0]   exp_data;
    logic [3:0]         exp_flags;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [2:0]       f;
    logic [WIDTH-1:0] r;
    logic             c, s1, s2;
    logic [CNT_BITS-1:0] ret0;

    // expected flags are {V,C,N,Z}
    vecs[0] = '{3'd0, 8'h80, 1'b0, 1'b0, 1'b0, 3'd3, 1'b1, 8'h80, 4'b1010}; // ADD 7F+01
`ifdef ALU_WB_SAT_EN
    vecs[1] = '{3'd0, 8'h00, 1'b1, 1'b1, 1'b0, 3'd1, 1'b1, 8'hFF, 4'b0110}; // ADD FF+01 sat
`else
    vecs[1] = '{3'd0, 8'h00, 1'b1, 1'b1, 1'b0, 3'd1, 1'b1, 8'h00, 4'b0101}; // ADD FF+01
`endif
    vecs[2] = '{3'd1, 8'h7F, 1'b0, 1'b1, 1'b0, 3'd2, 1'b1, 8'h7F, 4'b1000}; // SUB 80-01
    vecs[3] = '{3'd2, 8'h00, 1'b1, 1'b0, 1'b1, 3'd4, 1'b1, 8'h00, 4'b0001}; // AND, C ignored
    vecs[4] = '{3'd5, 8'h02, 1'b1, 1'b1, 1'b1, 3'd5, 1'b1, 8'h02, 4'b0100}; // SHL 81
    vecs[5] = '{3'd6, 8'h00, 1'b1, 1'b0, 1'b0, 3'd6, 1'b1, 8'h00, 4'b0101}; // SHR 01
    vecs[6] = '{3'd4, 8'hFF, 1'b0, 1'b1, 1'b0, 3'd7, 1'b1, 8'hFF, 4'b0010}; // XOR
    vecs[7] = '{3'd7, 8'h00, 1'b0, 1'b1, 1'b1, 3'd0, 1'b1, 8'h00, 4'b0001}; // PASS, no V
`ifdef ALU_WB_SAT_EN
    vecs[8] = '{3'd0, 8'h00, 1'b1, 1'b1, 1'b1, 3'd3, 1'b1, 8'hFF, 4'b0110}; // ADD 80+80 sat
    vecs[9] = '{3'd3, 8'h00, 1'b0, 1'b0, 1'b0, 3'd2, 1'b0, 8'h00, 4'b0110}; // OR, we=0 holds
`else
    vecs[8] = '{3'd0, 8'h00, 1'b1, 1'b1, 1'b1, 3'd3, 1'b1, 8'h00, 4'b1101}; // ADD 80+80
    vecs[9] = '{3'd3, 8'h00, 1'b0, 1'b0, 1'b0, 3'd2, 1'b0, 8'h00, 4'b1101}; // OR, we=0 holds
`endif

    // ---- reset ----
    cycle(1'b1, 1'b0, 3'd0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 3'd0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    check("reset o_valid", o_valid, 1'b0);
    check("reset o_ready", o_ready, 1'b1);
    check("reset o_flags", o_flags, 4'b0000);
    check("reset o_retired", o_retired, 16'd0);
    check("reset o_data", o_data, 8'h00);
    check("reset o_rd", o_rd, 3'd0);

    // ---- table: single op, visible one edge after accept ----
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 1'b1, vecs[i].func, vecs[i].result, vecs[i].carry, vecs[i].s1,
            vecs[i].s2, vecs[i].rd, vecs[i].we, 1'b1);
      check($sformatf("vec%0d o_valid", i), o_valid, 1'b1);
      check($sformatf("vec%0d o_data", i), o_data, vecs[i].exp_data);
      check($sformatf("vec%0d o_rd", i), o_rd, vecs[i].rd);
      check($sformatf("vec%0d o_flags", i), o_flags, vecs[i].exp_flags);
      check_model($sformatf("vec%0d", i));
      idle(1'b1);
      check_model($sformatf("vec%0d drain", i));
    end

    // ---- backpressure: three ops, consumer stalled ----
    cycle(1'b0, 1'b1, 3'd7, 8'hA1, 1'b0, 1'b1, 1'b0, 3'd1, 1'b0, 1'b0);
    check("bp ready after 1st", o_ready, 1'b1);
    cycle(1'b0, 1'b1, 3'd7, 8'hB2, 1'b0, 1'b1, 1'b0, 3'd2, 1'b0, 1'b0);
    check("bp ready after 2nd", o_ready, 1'b0);
    for (int i = 0; i < 2; i++) begin
      cycle(1'b0, 1'b1, 3'd7, 8'hC3, 1'b0, 1'b1, 1'b0, 3'd3, 1'b0, 1'b0);
      check("bp head stable", o_data, 8'hA1);
      check("bp still full", o_ready, 1'b0);
      check_model("bp hold");
    end
    cycle(1'b0, 1'b1, 3'd7, 8'hC3, 1'b0, 1'b1, 1'b0, 3'd3, 1'b0, 1'b1);
    check("bp head 2nd", o_data, 8'hB2);
    check_model("bp drain1");
    cycle(1'b0, 1'b1, 3'd7, 8'hC3, 1'b0, 1'b1, 1'b0, 3'd3, 1'b0, 1'b1);
    check("bp head 3rd", o_data, 8'hC3);
    check_model("bp drain2");
    idle(1'b1);
    check("bp empty", o_valid, 1'b0);
    check_model("bp drain3");

    // ---- simultaneous accept and drain at count=1 ----
    cycle(1'b0, 1'b1, 3'd7, 8'h11, 1'b0, 1'b0, 1'b0, 3'd4, 1'b0, 1'b0);
    ret0 = o_retired;
    cycle(1'b0, 1'b1, 3'd7, 8'h22, 1'b0, 1'b0, 1'b0, 3'd5, 1'b0, 1'b1);
    check("simul o_ready", o_ready, 1'b1);
    check("simul o_valid", o_valid, 1'b1);
    check("simul head", o_data, 8'h22);
    check("simul retired", o_retired, ret0 + 16'd1);
    check_model("simul");
    idle(1'b1);
    check_model("simul drain");

    // ---- mid-stream reset with buffer full ----
    cycle(1'b0, 1'b1, 3'd0, 8'h80, 1'b0, 1'b0, 1'b0, 3'd1, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 3'd7, 8'h55, 1'b0, 1'b0, 1'b0, 3'd2, 1'b1, 1'b0);
    check("pre-reset full", o_ready, 1'b0);
    cycle(1'b1, 1'b1, 3'd0, 8'h80, 1'b0, 1'b0, 1'b0, 3'd1, 1'b1, 1'b1);
    cycle(1'b1, 1'b1, 3'd0, 8'h80, 1'b0, 1'b0, 1'b0, 3'd1, 1'b1, 1'b1);
    check("midrst o_valid", o_valid, 1'b0);
    check("midrst o_ready", o_ready, 1'b1);
    check("midrst o_flags", o_flags, 4'b0000);
    check("midrst o_retired", o_retired, 16'd0);
    check("midrst o_data", o_data, 8'h00);

    // ---- random traffic ----
    for (int i = 0; i < 400; i++) begin
      rand_op(f, r, c, s1, s2);
      cycle(1'b0, ($urandom_range(0, 9) < 7), f, r, c, s1, s2,
            RD_BITS'($urandom), 1'($urandom), ($urandom_range(0, 9) < 6));
      check_model("rand");
    end
    for (int i = 0; i < 3; i++) idle(1'b1);
    check_model("rand flush");

    // ---- flags hold with we=0, retire counter wraps after 65536 drains ----
    cycle(1'b1, 1'b0, 3'd0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 3'd0, 8'h80, 1'b0, 1'b0, 1'b0, 3'd3, 1'b1, 1'b0);
    check("wrap flags set", o_flags, 4'b1010);
    for (int i = 0; i < 65535; i++) begin
      cycle(1'b0, 1'b1, 3'd2, 8'h00, 1'b0, 1'b0, 1'b0, 3'd6, 1'b0, 1'b1);
      if ((i % 8192) == 0) check_model("wrap run");
    end
    check("wrap flags held", o_flags, 4'b1010);
    check("wrap retired max", o_retired, 16'hFFFF);
    check("wrap head AND", o_data, 8'h00);
    idle(1'b1);
    check("wrap retired zero", o_retired, 16'h0000);
    check("wrap empty", o_valid, 1'b0);
    check_model("wrap end");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
